// File: rtl/ctrl_pio_in.sv
// ctrl_pio_in: Avalon-MM input PIO with synchronizer, debounce, edge capture and maskable irq
module ctrl_pio_in #(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = 2,
  parameter int DEBOUNCE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  localparam int CW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
  logic [WIDTH-1:0] sync1_q, sync2_q, filt_q, filt_d, ecap_q, ecap_d, mask_q, mask_d;
  logic [WIDTH-1:0] chg, edg, clr, wdata;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr, rd, unused_wd;
  assign wr        = chipselect & ~write_n;
  assign rd        = chipselect & ~read_n;
  assign wdata     = writedata[WIDTH-1:0];
  assign unused_wd = ^(writedata >> WIDTH);
  generate
    if (DEBOUNCE == 0) begin : g_bypass
      assign filt_d = sync2_q;
    end else begin : g_deb
      logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
      // accept a new level only after it has been seen DEBOUNCE cycles in a row
      always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        for (int i = 0; i < WIDTH; i++) begin
          cnt_d[i]  = (sync2_q[i] == filt_q[i] || cnt_q[i] == CW'(DEBOUNCE - 1)) ? '0 : cnt_q[i] + 1'b1;
          filt_d[i] = (sync2_q[i] != filt_q[i] && cnt_q[i] == CW'(DEBOUNCE - 1)) ? sync2_q[i] : filt_q[i];
        end
      end
      // per-bit stability counters
      always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end
    end
  endgenerate
  assign chg    = filt_d ^ filt_q;
  assign edg    = (EDGE_TYPE == 0) ? (chg & filt_d) : (EDGE_TYPE == 1) ? (chg & ~filt_d) : chg;
  assign clr    = (wr && address == 2'd3) ? wdata : '0;
  assign ecap_d = (ecap_q & ~clr) | edg;
  assign mask_d = (wr && address == 2'd2) ? wdata : mask_q;
  // read mux sampled only on a read strobe, otherwise the last value holds
  always_comb begin
    readdata_d = readdata_q;
    if (rd)
      readdata_d = (address == 2'd0) ? 32'(filt_q) :
                   (address == 2'd2) ? 32'(mask_q) :
                   (address == 2'd3) ? 32'(ecap_q) : 32'd0;
  end
  // synchronizer, filtered value, edge capture, mask and read data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      filt_q     <= '0;
      ecap_q     <= '0;
      mask_q     <= '0;
      readdata_q <= '0;
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      ecap_q     <= ecap_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
    end
  end
  assign readdata = readdata_q;
  assign irq      = |(ecap_q & mask_q);
endmodule

// File: tb/tb_ctrl_pio_in.sv
// tb_ctrl_pio_in: scoreboard bench for three ctrl_pio_in configurations sharing one bus
module tb_ctrl_pio_in;
  logic        clk = 0;
  logic        reset = 1;
  logic [1:0]  address = 0;
  logic        chipselect = 0, read_n = 1, write_n = 1;
  logic [31:0] writedata = 0;
  logic [7:0]  in_port = 8'hA5;
  logic [31:0] rdata [3];
  logic        irq_w [3];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  ctrl_pio_in #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE(0)) dut0 (.clk(clk), .reset(reset), .address(address),
    .chipselect(chipselect), .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rdata[0]), .irq(irq_w[0]));
  ctrl_pio_in #(.WIDTH(8), .EDGE_TYPE(1), .DEBOUNCE(4)) dut1 (.clk(clk), .reset(reset), .address(address),
    .chipselect(chipselect), .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rdata[1]), .irq(irq_w[1]));
  ctrl_pio_in #(.WIDTH(8), .EDGE_TYPE(2), .DEBOUNCE(0)) dut2 (.clk(clk), .reset(reset), .address(address),
    .chipselect(chipselect), .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rdata[2]), .irq(irq_w[2]));

  function automatic int et(input int k); return k; endfunction
  function automatic int db(input int k); return (k == 1) ? 4 : 0; endfunction

  task automatic chk(input string n, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", n, k, got, exp, $time);
    end
  endtask

  // reference model: input delay line, run-length debounce over a sample history, sticky captures
  typedef struct { int k; logic [31:0] v; } exp_t;
  exp_t sb[$];
  logic [7:0] m_s1 [3], m_s2 [3], m_filt [3], m_ecap [3], m_mask [3];
  logic [7:0] m_hist [3][8];
  logic [7:0] nf, ch, ed, clr;
  logic       stable, wr_s, rd_s, rd_fired = 0, m_rst = 1;
  exp_t       e;

  initial for (int k = 0; k < 3; k++) begin
    m_s1[k] = 0; m_s2[k] = 0; m_filt[k] = 0; m_ecap[k] = 0; m_mask[k] = 0;
    for (int j = 0; j < 8; j++) m_hist[k][j] = 0;
  end

  always @(posedge clk) begin
    rd_fired = 0;
    m_rst = reset;
    wr_s = chipselect & ~write_n;
    rd_s = chipselect & ~read_n;
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        m_s1[k] = 0; m_s2[k] = 0; m_filt[k] = 0; m_ecap[k] = 0; m_mask[k] = 0;
        for (int j = 0; j < 8; j++) m_hist[k][j] = 0;
      end else begin
        if (rd_s) begin
          e.k = k;
          e.v = (address == 0) ? {24'b0, m_filt[k]} : (address == 2) ? {24'b0, m_mask[k]} :
                (address == 3) ? {24'b0, m_ecap[k]} : 32'b0;
          sb.push_back(e);
        end
        for (int j = 7; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
        m_hist[k][0] = m_s2[k];
        nf = m_filt[k];
        if (db(k) == 0) nf = m_s2[k];
        else for (int b = 0; b < 8; b++) begin
          stable = 1;
          for (int j = 0; j < db(k); j++) if (m_hist[k][j][b] == m_filt[k][b]) stable = 0;
          if (stable) nf[b] = ~m_filt[k][b];
        end
        ch = nf ^ m_filt[k];
        ed = (et(k) == 0) ? (ch & nf) : (et(k) == 1) ? (ch & ~nf) : ch;
        clr = (wr_s && address == 3) ? writedata[7:0] : 8'h00;
        m_ecap[k] = (m_ecap[k] & ~clr) | ed;
        if (wr_s && address == 2) m_mask[k] = writedata[7:0];
        m_filt[k] = nf;
        m_s2[k] = m_s1[k];
        m_s1[k] = in_port;
      end
    end
    if (!reset) rd_fired = rd_s;
  end

  // monitor: irq every cycle, readdata whenever a read completed at the last edge
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk("irq", k, {31'b0, irq_w[k]}, {31'b0, |(m_ecap[k] & m_mask[k])});
      if (m_rst) chk("reset_readdata", k, rdata[k], 32'h0);
    end
    if (rd_fired) for (int k = 0; k < 3; k++) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty dut%0d: got %h expected a queued value", k, rdata[k]);
      end else begin
        e = sb.pop_front();
        chk("readdata", e.k, rdata[e.k], e.v);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus(input logic w, input logic r, input logic [1:0] a, input logic [31:0] d);
    chipselect = 1; write_n = ~w; read_n = ~r; address = a; writedata = d;
    cyc();
    chipselect = 0; write_n = 1; read_n = 1;
  endtask

  initial begin
    cyc(2);
    reset = 0;
    cyc(4);
    bus(0, 1, 2'd0, 0);
    chk("data_after_reset", 0, rdata[0], 32'h000000A5);
    chk("data_after_reset", 2, rdata[2], 32'h000000A5);
    bus(0, 1, 2'd1, 0);
    chk("reserved_read", 0, rdata[0], 32'h0);
    in_port = 8'h00;
    cyc(8);
    bus(1, 0, 2'd3, 32'hFF);
    bus(1, 0, 2'd2, 32'h01);
    in_port = 8'h01;
    cyc(3);
    chk("irq_after_e2", 0, {31'b0, irq_w[0]}, 32'h1);
    bus(0, 1, 2'd3, 0);
    chk("edgecap_bit0", 0, rdata[0], 32'h1);
    bus(1, 0, 2'd3, 32'h1);
    chk("irq_cleared", 0, {31'b0, irq_w[0]}, 32'h0);
    in_port = 8'h09; cyc(8); bus(0, 1, 2'd3, 0);
    in_port = 8'h01; cyc(8); bus(0, 1, 2'd3, 0);
    in_port = 8'h03; cyc(3); in_port = 8'h01; cyc(8);
    bus(0, 1, 2'd0, 0); bus(0, 1, 2'd3, 0);
    in_port = 8'h03; cyc(6); bus(0, 1, 2'd0, 0);
    bus(1, 0, 2'd3, 32'hFF);
    in_port = 8'h07;
    cyc(2);
    bus(1, 0, 2'd3, 32'h04);
    bus(0, 1, 2'd3, 0);
    chk("clear_vs_edge", 0, rdata[0] & 32'h4, 32'h4);
    chk("clear_vs_edge", 2, rdata[2] & 32'h4, 32'h4);
    bus(1, 0, 2'd3, 32'hFF);
    bus(1, 0, 2'd2, 32'h00);
    in_port = 8'h37;
    cyc(8);
    chk("masked_irq", 0, {31'b0, irq_w[0]}, 32'h0);
    bus(1, 0, 2'd2, 32'h10);
    chk("unmasked_irq", 0, {31'b0, irq_w[0]}, 32'h1);
    bus(1, 0, 2'd0, 32'h00);
    bus(0, 1, 2'd0, 0);
    chk("data_write_ignored", 0, rdata[0], 32'h37);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) in_port[$urandom_range(0, 7)] ^= 1'b1;
      if ($urandom_range(0, 40) == 0) in_port = 8'($urandom);
      reset = ($urandom_range(0, 600) == 0);
      case ($urandom_range(0, 5))
        0: bus(0, 1, 2'($urandom), 0);
        1: bus(1, 0, 2'($urandom), $urandom);
        2: bus(1, 1, 2'($urandom), $urandom);
        default: cyc();
      endcase
    end
    reset = 0;
    cyc(3);
    chk("scoreboard_drained", 0, sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
